// File: rtl/iop_writeback.sv
// Writeback stage behind the integer-op unit: captures the destination at issue, selects the
// registered result a cycle later, queues it in an FWFT FIFO and drains it to the register file.
module iop_writeback #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  en,
    input  logic                  iop_wr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic                  flags_we,
    input  logic                  in_cf,
    input  logic                  in_of,
    input  logic                  in_zf,
    input  logic [1:0]            dout_select,
    input  logic [WIDTH-1:0]      dout1,
    input  logic [WIDTH-1:0]      dout2,
    input  logic [WIDTH-1:0]      dout3,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_ready,
    output logic                  stall,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  hazard,
    output logic                  flag_cf,
    output logic                  flag_of,
    output logic                  flag_zf,
    output logic                  busy,
    output logic                  err_sel
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [WIDTH-1:0]      r_mem_data [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_cf;
    logic                  r_of;
    logic                  r_zf;
    logic                  r_err_sel;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [WIDTH-1:0]      w_sel_data;
    logic [CW-1:0]         w_occupancy;
    logic [PW-1:0]         w_offset;
    logic                  w_fifo_hit;

    // Stall looks only at registered occupancy so there is no combinational path from en.
    assign w_occupancy = r_count + CW'(r_pend_valid);
    assign stall       = (w_occupancy >= CW'(DEPTH));
    assign w_accept    = en & ~stall;
    assign wr_valid    = (r_count != '0);
    assign w_pop       = wr_valid & wr_ready;
    assign w_push      = r_pend_valid & (dout_select != 2'd0);

    always_comb begin
        w_sel_data = '0;
        case (dout_select)
            2'd1:    w_sel_data = dout1;
            2'd2:    w_sel_data = dout2;
            2'd3:    w_sel_data = dout3;
            default: w_sel_data = '0;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        w_offset   = '0;
        w_fifo_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_offset = PW'(i) - r_rptr;
            if (({1'b0, w_offset} < r_count) && (r_mem_addr[i] == rd_addr)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    assign hazard  = (r_pend_valid & (r_pend_addr == rd_addr)) | w_fifo_hit;
    assign busy    = r_pend_valid | wr_valid;
    assign wr_addr = r_mem_addr[r_rptr];
    assign wr_data = r_mem_data[r_rptr];
    assign flag_cf = r_cf;
    assign flag_of = r_of;
    assign flag_zf = r_zf;
    assign err_sel = r_err_sel;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= r_pend_addr;
            r_mem_data[r_wptr] <= w_sel_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_cf         <= 1'b0;
            r_of         <= 1'b0;
            r_zf         <= 1'b0;
            r_err_sel    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= iop_wr;
                if (iop_wr) begin
                    r_pend_addr <= dst_addr;
                end
                if (flags_we) begin
                    r_cf <= in_cf;
                    r_of <= in_of;
                    r_zf <= in_zf;
                end
            end else begin
                r_pend_valid <= 1'b0;
            end

            if (r_pend_valid && (dout_select == 2'd0)) begin
                r_err_sel <= 1'b1;
            end

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
